tri_setup: RTL and testbench

Per-triangle setup stage between the vertex shader and the rasterizer. It takes the three screen-space vertices and sequentially computes the three edge-function coefficient sets (A, B, C) and the doubled signed area, using one shared multiplier. Results are held in a shadow register set. They are promoted to the rasterizer-facing outputs only on a frame-start pulse, so the rasterizer never sees a triangle change mid-frame.

---
 rtl/raster_pkg.sv | 26 ++
 rtl/setup_mul.sv | 37 +++
 rtl/tri_setup.sv | 190 +++++++++++++++++++
 tb/tb_tri_setup.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: shared widths, setup FSM state encoding and the edge
// coefficient record used by the triangle setup stage.
//   COORD_W : vertex coordinate width (unsigned pixels)
//   COEF_W  : signed edge x/y coefficient width (coordinate difference)
//   CONST_W : signed edge constant width (difference of two products)
//   AREA_W  : signed doubled-area width (sum of three edge constants)
package raster_pkg;
    localparam int COORD_W = 10;
    localparam int COEF_W  = 11;
    localparam int CONST_W = 21;
    localparam int AREA_W  = 22;
    localparam int PROD_W  = 2 * COORD_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        COMBINE = 2'd2,
        AREA    = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [COEF_W-1:0]  a;
        logic signed [COEF_W-1:0]  b;
        logic signed [CONST_W-1:0] c;
    } edge_coef_t;
endpackage

// File: rtl/setup_mul.sv
// setup_mul: the single shared multiplier of the setup stage. Purely
// combinational; k_i selects which of the six cross products is formed,
// the parent registers the result.
// Ports:
//   ax_i..cy_i : latched vertex coordinates
//   k_i        : product index 0..5 (bx*cy, cx*by, cx*ay, ax*cy, ax*by, bx*ay)
//   prod_o     : full-width unsigned product
module setup_mul
    import raster_pkg::*;
(
    input  logic [COORD_W-1:0] ax_i,
    input  logic [COORD_W-1:0] ay_i,
    input  logic [COORD_W-1:0] bx_i,
    input  logic [COORD_W-1:0] by_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [2:0]         k_i,
    output logic [PROD_W-1:0]  prod_o
);
    logic [COORD_W-1:0] op_x;
    logic [COORD_W-1:0] op_y;

    always_comb begin
        op_x = '0;
        op_y = '0;
        case (k_i)
            3'd0: begin op_x = bx_i; op_y = cy_i; end
            3'd1: begin op_x = cx_i; op_y = by_i; end
            3'd2: begin op_x = cx_i; op_y = ay_i; end
            3'd3: begin op_x = ax_i; op_y = cy_i; end
            3'd4: begin op_x = ax_i; op_y = by_i; end
            3'd5: begin op_x = bx_i; op_y = ay_i; end
            default: ;
        endcase
        prod_o = PROD_W'(op_x) * PROD_W'(op_y);
    end
endmodule

// File: rtl/tri_setup.sv
// tri_setup: per-triangle setup. Computes the three edge functions
// E(x,y) = A*x + B*y + C and the doubled signed area with one shared
// multiplier, keeps the result in a shadow set and promotes it to the
// rasterizer-facing outputs only on frame_start.
// Ports:
//   clk_pix, rst          : clock, asynchronous active-high reset
//   start                 : run setup on ax..cy (ignored while busy)
//   frame_start           : promote the pending shadow set
//   ax, ay, bx, by, cx, cy: vertex coordinates, sampled on accepted start
//   busy, done, overrun   : progress / completion pulse / lost-result pulse
//   a0..a2, b0..b2, c0..c2: active edge coefficients (edge0=B->C, 1=C->A, 2=A->B)
//   area, cull, valid     : active doubled area, drop flag, active set valid
//   state_dbg             : current FSM state, for observation only
// Build option: TRI_SETUP_BACKFACE_CULL_EN -> cull = (area <= 0);
//               otherwise cull = (area == 0).
module tri_setup #(
    parameter int COORD_W = 10
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    frame_start,
    input  logic [COORD_W-1:0]      ax,
    input  logic [COORD_W-1:0]      ay,
    input  logic [COORD_W-1:0]      bx,
    input  logic [COORD_W-1:0]      by,
    input  logic [COORD_W-1:0]      cx,
    input  logic [COORD_W-1:0]      cy,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic signed [COORD_W:0] a0,
    output logic signed [COORD_W:0] a1,
    output logic signed [COORD_W:0] a2,
    output logic signed [COORD_W:0] b0,
    output logic signed [COORD_W:0] b1,
    output logic signed [COORD_W:0] b2,
    output logic signed [2*COORD_W:0]   c0,
    output logic signed [2*COORD_W:0]   c1,
    output logic signed [2*COORD_W:0]   c2,
    output logic signed [2*COORD_W+1:0] area,
    output logic                    cull,
    output logic                    valid,
    output logic [1:0]              state_dbg
);
    import raster_pkg::*;

    state_t              state_q;
    logic [2:0]          k_q;
    logic [COORD_W-1:0]  ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [PROD_W-1:0]   p_q [6];
    logic [PROD_W-1:0]   mul_prod;

    // stg_q holds the coefficients of the triangle in flight; they join the
    // shadow set together with area/cull in the AREA cycle so a promotion
    // never mixes coefficients of two different triangles.
    edge_coef_t          stg_q [3];
    edge_coef_t          sh_q  [3];
    logic signed [AREA_W-1:0] sh_area_q;
    logic                sh_cull_q;
    logic                pending_q;

    edge_coef_t          act_q [3];
    logic signed [AREA_W-1:0] act_area_q;
    logic                act_cull_q;
    logic                valid_q, busy_q, done_q, overrun_q;

    edge_coef_t          comb_e [3];
    logic signed [AREA_W-1:0] area_sum;
    logic                cull_calc;

    setup_mul u_mul (
        .ax_i(ax_q), .ay_i(ay_q), .bx_i(bx_q), .by_i(by_q),
        .cx_i(cx_q), .cy_i(cy_q), .k_i(k_q), .prod_o(mul_prod)
    );

    always_comb begin
        comb_e[0].a = COEF_W'(by_q) - COEF_W'(cy_q);
        comb_e[0].b = COEF_W'(cx_q) - COEF_W'(bx_q);
        comb_e[0].c = CONST_W'(p_q[0]) - CONST_W'(p_q[1]);
        comb_e[1].a = COEF_W'(cy_q) - COEF_W'(ay_q);
        comb_e[1].b = COEF_W'(ax_q) - COEF_W'(cx_q);
        comb_e[1].c = CONST_W'(p_q[2]) - CONST_W'(p_q[3]);
        comb_e[2].a = COEF_W'(ay_q) - COEF_W'(by_q);
        comb_e[2].b = COEF_W'(bx_q) - COEF_W'(ax_q);
        comb_e[2].c = CONST_W'(p_q[4]) - CONST_W'(p_q[5]);

        area_sum = {stg_q[0].c[CONST_W-1], stg_q[0].c}
                 + {stg_q[1].c[CONST_W-1], stg_q[1].c}
                 + {stg_q[2].c[CONST_W-1], stg_q[2].c};
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        cull_calc = area_sum[AREA_W-1] || (area_sum == '0);
`else
        cull_calc = (area_sum == '0);
`endif
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ax_q <= '0; ay_q <= '0; bx_q <= '0;
            by_q <= '0; cx_q <= '0; cy_q <= '0;
            for (int i = 0; i < 6; i++) p_q[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                stg_q[i] <= '0;
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
            sh_area_q  <= '0;
            sh_cull_q  <= 1'b0;
            pending_q  <= 1'b0;
            act_area_q <= '0;
            act_cull_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        ax_q <= ax; ay_q <= ay; bx_q <= bx;
                        by_q <= by; cx_q <= cx; cy_q <= cy;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    for (int i = 0; i < 6; i++)
                        if (k_q == 3'(i)) p_q[i] <= mul_prod;
                    if (k_q == 3'd5) state_q <= COMBINE;
                    else             k_q     <= k_q + 3'd1;
                end
                COMBINE: begin
                    for (int i = 0; i < 3; i++) stg_q[i] <= comb_e[i];
                    state_q <= AREA;
                end
                AREA: begin
                    for (int i = 0; i < 3; i++) sh_q[i] <= stg_q[i];
                    sh_area_q <= area_sum;
                    sh_cull_q <= cull_calc;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Promotion copies the pre-edge shadow set, so a result landing
            // in the same cycle stays pending for the following frame.
            if (frame_start && pending_q) begin
                for (int i = 0; i < 3; i++) act_q[i] <= sh_q[i];
                act_area_q <= sh_area_q;
                act_cull_q <= sh_cull_q;
                valid_q    <= 1'b1;
            end

            // An older pending result is only lost if it is not being
            // promoted on this very edge.
            if (state_q == AREA) begin
                pending_q <= 1'b1;
                overrun_q <= pending_q && !frame_start;
            end else if (frame_start) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign a0        = act_q[0].a;
    assign a1        = act_q[1].a;
    assign a2        = act_q[2].a;
    assign b0        = act_q[0].b;
    assign b1        = act_q[1].b;
    assign b2        = act_q[2].b;
    assign c0        = act_q[0].c;
    assign c1        = act_q[1].c;
    assign c2        = act_q[2].c;
    assign area      = act_area_q;
    assign cull      = act_cull_q;
    assign valid     = valid_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_tri_setup.sv
// tb_tri_setup: self-checking bench for tri_setup. A transaction-level model
// computes edge functions from vertex geometry and tracks the pending /
// active result sets; directed triangles plus randomized ones.
module tb_tri_setup;
    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
    logic        busy, done, overrun, cull, valid;
    logic signed [10:0] a0, a1, a2, b0, b1, b2;
    logic signed [20:0] c0, c1, c2;
    logic signed [21:0] area;
    logic [1:0]  state_dbg;

    tri_setup #(.COORD_W(10)) dut (
        .clk_pix(clk_pix), .rst(rst), .start(start), .frame_start(frame_start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy), .done(done), .overrun(overrun),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .c0(c0), .c1(c1), .c2(c2), .area(area), .cull(cull), .valid(valid),
        .state_dbg(state_dbg)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        int a0, a1, a2, b0, b1, b2, c0, c1, c2, area;
        bit cull;
    } res_t;

    int   n_checks = 0;
    int   n_pass = 0;
    res_t act = '0;
    bit   act_valid = 1'b0;
    res_t pend_res = '0;
    bit   pend = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Edge from P0 to P1: E(x,y) = (y0-y1)x + (x1-x0)y + (x0*y1 - x1*y0).
    function automatic void edge_fn(input int x0, input int y0, input int x1, input int y1,
                                    output int ea, output int eb, output int ec);
        ea = y0 - y1;
        eb = x1 - x0;
        ec = x0 * y1 - x1 * y0;
    endfunction

    function automatic res_t model(input int xa, input int ya, input int xb,
                                   input int yb, input int xc, input int yc);
        res_t r;
        edge_fn(xb, yb, xc, yc, r.a0, r.b0, r.c0);
        edge_fn(xc, yc, xa, ya, r.a1, r.b1, r.c1);
        edge_fn(xa, ya, xb, yb, r.a2, r.b2, r.c2);
        r.area = r.c0 + r.c1 + r.c2;
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        r.cull = (r.area <= 0);
`else
        r.cull = (r.area == 0);
`endif
        return r;
    endfunction

    task automatic check_active();
        check("a0", a0, act.a0); check("a1", a1, act.a1); check("a2", a2, act.a2);
        check("b0", b0, act.b0); check("b1", b1, act.b1); check("b2", b2, act.b2);
        check("c0", c0, act.c0); check("c1", c1, act.c1); check("c2", c2, act.c2);
        check("area", area, act.area);
        check("cull", cull, act.cull);
        check("valid", valid, act_valid);
    endtask

    task automatic rand_coords();
        ax = 10'($urandom_range(0, 1023)); ay = 10'($urandom_range(0, 1023));
        bx = 10'($urandom_range(0, 1023)); by = 10'($urandom_range(0, 1023));
        cx = 10'($urandom_range(0, 1023)); cy = 10'($urandom_range(0, 1023));
    endtask

    // Entered and left #1 after a rising edge. start is accepted in cycle N;
    // the loop covers cycles N+1..N+8, done is checked in N+9.
    task automatic run_setup(input int xa, input int ya, input int xb, input int yb,
                             input int xc, input int yc, input bit fs_in_area,
                             input bit poke_busy);
        res_t exp_r;
        bit   ovr_exp;
        bit   had_pend;
        ax = 10'(xa); ay = 10'(ya); bx = 10'(xb); by = 10'(yb); cx = 10'(xc); cy = 10'(yc);
        start = 1'b1;
        @(posedge clk_pix); #1;
        start = 1'b0;
        rand_coords();
        for (int i = 1; i <= 8; i++) begin
            if (poke_busy && i == 3) begin
                start = 1'b1;
                rand_coords();
            end
            if (fs_in_area && i == 8) frame_start = 1'b1;
            @(negedge clk_pix);
            if (i == 1 || i == 8) begin
                check("busy_run", busy, 1);
                check("done_early", done, 0);
            end
            check("area_hold", area, act.area);
            @(posedge clk_pix); #1;
            start = 1'b0;
            frame_start = 1'b0;
        end
        exp_r    = model(xa, ya, xb, yb, xc, yc);
        had_pend = pend;
        ovr_exp  = pend && !fs_in_area;
        if (fs_in_area && pend) begin
            act = pend_res;
            act_valid = 1'b1;
        end
        pend = 1'b1;
        pend_res = exp_r;
        @(negedge clk_pix);
        check("done_n9", done, 1);
        check("busy_n9", busy, 0);
        if (!(fs_in_area && had_pend)) check("overrun", overrun, ovr_exp);
        check_active();
        @(posedge clk_pix); #1;
        @(negedge clk_pix);
        check("done_pulse", done, 0);
        check("overrun_pulse", overrun, 0);
        @(posedge clk_pix); #1;
    endtask

    task automatic do_frame();
        frame_start = 1'b1;
        @(posedge clk_pix); #1;
        frame_start = 1'b0;
        if (pend) begin
            act = pend_res;
            act_valid = 1'b1;
            pend = 1'b0;
        end
        @(negedge clk_pix);
        check_active();
        @(posedge clk_pix); #1;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        check_active();
        @(negedge clk_pix);
        rst = 1'b0;
        @(posedge clk_pix); #1;

        // frame_start with nothing pending changes nothing
        do_frame();

        // Reference triangle
        run_setup(100, 100, 200, 100, 100, 200, 1'b0, 1'b0);
        check("pre_promote_valid", valid, 0);
        do_frame();
        check("tp_a0", a0, -100); check("tp_b0", b0, -100); check("tp_c0", c0, 30000);
        check("tp_a1", a1, 100);  check("tp_b1", b1, 0);    check("tp_c1", c1, -10000);
        check("tp_a2", a2, 0);    check("tp_b2", b2, 100);  check("tp_c2", c2, -10000);
        check("tp_area", area, 10000);
        check("tp_cull", cull, 0);

        // Opposite winding
        run_setup(100, 100, 100, 200, 200, 100, 1'b0, 1'b0);
        do_frame();
        check("cw_area", area, -10000);

        // Collinear
        run_setup(0, 0, 10, 10, 20, 20, 1'b0, 1'b0);
        do_frame();
        check("col_area", area, 0);
        check("col_cull", cull, 1);

        // Extremes, with a start poked while busy
        run_setup(0, 0, 639, 0, 0, 479, 1'b0, 1'b1);
        do_frame();
        check("ext_c0", c0, 306081);
        check("ext_area", area, 306081);

        // Two setups without a frame in between: overrun, newest promoted
        run_setup(5, 7, 300, 20, 40, 400, 1'b0, 1'b0);
        run_setup(1000, 3, 2, 900, 500, 500, 1'b0, 1'b0);
        do_frame();

        // frame_start in the AREA cycle: old result promoted, new one pending
        run_setup(10, 10, 50, 10, 10, 60, 1'b0, 1'b0);
        run_setup(700, 100, 20, 30, 400, 600, 1'b1, 1'b0);
        do_frame();

        // Reset during MUL
        ax = 10'd11; ay = 10'd12; bx = 10'd300; by = 10'd40; cx = 10'd90; cy = 10'd500;
        start = 1'b1;
        @(posedge clk_pix); #1;
        start = 1'b0;
        repeat (2) @(posedge clk_pix);
        #2;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        act = '0;
        act_valid = 1'b0;
        pend = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", state_dbg, 0);
        check_active();
        @(negedge clk_pix);
        rst = 1'b0;
        @(posedge clk_pix); #1;
        do_frame();
        run_setup(123, 45, 600, 222, 321, 470, 1'b0, 1'b0);
        check("post_rst_overrun", overrun, 0);
        do_frame();

        // Randomized triangles
        for (int t = 0; t < 16; t++) begin
            int xa, ya, xb, yb, xc, yc;
            xa = $urandom_range(0, 1023); ya = $urandom_range(0, 1023);
            xb = $urandom_range(0, 1023); yb = $urandom_range(0, 1023);
            xc = $urandom_range(0, 1023); yc = $urandom_range(0, 1023);
            run_setup(xa, ya, xb, yb, xc, yc,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 1) == 1) do_frame();
        end
        do_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
